decode_queue: RTL and testbench

//  Buffered decode/dispatch stage between ifetch and the ROB/RS/LSB back end; successor to the combinational decoder.

---
 rtl/decode_queue_pkg.sv | 48 ++++
 rtl/decode_queue_inst_decode.sv | 129 ++++++++++++
 rtl/decode_queue.sv | 188 ++++++++++++++++++
 tb/tb_decode_queue.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_queue_pkg.sv
// Shared op_type codes, opcode constants and packed types for the decode queue.
package decode_queue_pkg;

    localparam int ROB_ID_BITS = 4;
    localparam int REG_ID_BITS = 5;

    typedef enum logic [5:0] {
        OP_LUI   = 6'd0,  OP_AUIPC = 6'd1,  OP_JAL   = 6'd2,  OP_JALR  = 6'd3,
        OP_BEQ   = 6'd4,  OP_BNE   = 6'd5,  OP_BLT   = 6'd6,  OP_BGE   = 6'd7,
        OP_BLTU  = 6'd8,  OP_BGEU  = 6'd9,  OP_LB    = 6'd10, OP_LH    = 6'd11,
        OP_LW    = 6'd12, OP_LBU   = 6'd13, OP_LHU   = 6'd14, OP_SB    = 6'd15,
        OP_SH    = 6'd16, OP_SW    = 6'd17, OP_ADDI  = 6'd18, OP_SLTI  = 6'd19,
        OP_SLTIU = 6'd20, OP_XORI  = 6'd21, OP_ORI   = 6'd22, OP_ANDI  = 6'd23,
        OP_SLLI  = 6'd24, OP_SRLI  = 6'd25, OP_SRAI  = 6'd26, OP_ADD   = 6'd27,
        OP_SUB   = 6'd28, OP_SLL   = 6'd29, OP_SLT   = 6'd30, OP_SLTU  = 6'd31,
        OP_XOR   = 6'd32, OP_SRL   = 6'd33, OP_SRA   = 6'd34, OP_OR    = 6'd35,
        OP_AND   = 6'd36, OP_FENCE = 6'd37, OP_EXIT  = 6'd38, OP_ILLEGAL = 6'd39
    } op_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        predict;
    } iq_entry_t;

    // rs1/rs2/rd are already zero when the instruction does not use them
    typedef struct packed {
        op_t         op;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        to_lsb;
    } dec_t;

endpackage

// File: rtl/decode_queue_inst_decode.sv
// Combinational RV32I decoder: {inst,pc} -> op_type, immediate, used register ids, target unit.
// Zero latency; no flow control.
module decode_queue_inst_decode
    import decode_queue_pkg::*;
(
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    output dec_t        dec
);
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
    op_t         op;
    logic [31:0] imm;
    logic        use_rs1, use_rs2, use_rd;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign shamt  = {27'b0, inst[24:20]};

    always_comb begin
        op      = OP_ILLEGAL;
        imm     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        case (opcode)
            OPC_LUI:   begin op = OP_LUI;   imm = imm_u;      use_rd = 1'b1; end
            OPC_AUIPC: begin op = OP_AUIPC; imm = pc + imm_u; use_rd = 1'b1; end
            OPC_JAL:   begin op = OP_JAL;   imm = imm_j;      use_rd = 1'b1; end
            OPC_JALR: if (funct3 == 3'b000) begin
                op = OP_JALR; imm = imm_i; use_rs1 = 1'b1; use_rd = 1'b1;
            end
            OPC_BRANCH: begin
                imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1;
                case (funct3)
                    3'b000:  op = OP_BEQ;
                    3'b001:  op = OP_BNE;
                    3'b100:  op = OP_BLT;
                    3'b101:  op = OP_BGE;
                    3'b110:  op = OP_BLTU;
                    3'b111:  op = OP_BGEU;
                    default: op = OP_ILLEGAL;
                endcase
            end
            OPC_LOAD: begin
                imm = imm_i; use_rs1 = 1'b1; use_rd = 1'b1;
                case (funct3)
                    3'b000:  op = OP_LB;
                    3'b001:  op = OP_LH;
                    3'b010:  op = OP_LW;
                    3'b100:  op = OP_LBU;
                    3'b101:  op = OP_LHU;
                    default: op = OP_ILLEGAL;
                endcase
            end
            OPC_STORE: begin
                imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
                case (funct3)
                    3'b000:  op = OP_SB;
                    3'b001:  op = OP_SH;
                    3'b010:  op = OP_SW;
                    default: op = OP_ILLEGAL;
                endcase
            end
            OPC_OPIMM: begin
                imm = imm_i; use_rs1 = 1'b1; use_rd = 1'b1;
                case (funct3)
                    3'b000: op = OP_ADDI;
                    3'b010: op = OP_SLTI;
                    3'b011: op = OP_SLTIU;
                    3'b100: op = OP_XORI;
                    3'b110: op = OP_ORI;
                    3'b111: op = OP_ANDI;
                    3'b001: begin
                        imm = shamt;
                        op  = (funct7 == 7'h00) ? OP_SLLI : OP_ILLEGAL;
                    end
                    default: begin
                        imm = shamt;
                        if (funct7 == 7'h00)      op = OP_SRLI;
                        else if (funct7 == 7'h20) op = OP_SRAI;
                    end
                endcase
            end
            OPC_OP: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                case ({funct7, funct3})
                    {7'h00, 3'b000}: op = OP_ADD;
                    {7'h20, 3'b000}: op = OP_SUB;
                    {7'h00, 3'b001}: op = OP_SLL;
                    {7'h00, 3'b010}: op = OP_SLT;
                    {7'h00, 3'b011}: op = OP_SLTU;
                    {7'h00, 3'b100}: op = OP_XOR;
                    {7'h00, 3'b101}: op = OP_SRL;
                    {7'h20, 3'b101}: op = OP_SRA;
                    {7'h00, 3'b110}: op = OP_OR;
                    {7'h00, 3'b111}: op = OP_AND;
                    default:         op = OP_ILLEGAL;
                endcase
            end
            OPC_FENCE:  op = OP_FENCE;
            OPC_SYSTEM: op = OP_EXIT;
            default:    op = OP_ILLEGAL;
        endcase
        // An illegal word carries no operands and renames nothing
        if (op == OP_ILLEGAL) begin
            imm = '0; use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0;
        end
    end

    always_comb begin
        dec        = '0;
        dec.op     = op;
        dec.imm    = imm;
        dec.rs1    = use_rs1 ? inst[19:15] : 5'd0;
        dec.rs2    = use_rs2 ? inst[24:20] : 5'd0;
        dec.rd     = use_rd  ? inst[11:7]  : 5'd0;
        dec.to_lsb = (op >= OP_LB) && (op <= OP_SW);
    end

endmodule

// File: rtl/decode_queue.sv
// Fetch queue feeding decode/rename/dispatch; entry dispatchable one cycle after push, packet registered.
// Stalls head on rob_full or target-unit full; if_ready drops at IQ_DEPTH entries, rdy_in=0 freezes all state.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int IQ_DEPTH = 8,
    parameter int ROB_ID_W = ROB_ID_BITS,
    parameter int REG_ID_W = REG_ID_BITS
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                rdy_in,
    input  logic                flush_in,
    input  logic                if_valid,
    input  logic [31:0]         if_pc,
    input  logic [31:0]         if_inst,
    input  logic                if_predict,
    output logic                if_ready,
    input  logic                rs1_busy,
    input  logic                rs2_busy,
    input  logic [31:0]         rs1_value,
    input  logic [31:0]         rs2_value,
    input  logic [ROB_ID_W-1:0] rs1_re,
    input  logic [ROB_ID_W-1:0] rs2_re,
    input  logic                rob_rs1_ready,
    input  logic                rob_rs2_ready,
    input  logic [31:0]         rob_rs1_value,
    input  logic [31:0]         rob_rs2_value,
    input  logic                rob_full,
    input  logic [ROB_ID_W-1:0] rob_free_id,
    input  logic                rs_full,
    input  logic                lsb_full,
    input  logic                cdb_valid,
    input  logic [ROB_ID_W-1:0] cdb_rob_id,
    input  logic [31:0]         cdb_value,
    output logic [REG_ID_W-1:0] rs1_id,
    output logic [REG_ID_W-1:0] rs2_id,
    output logic                reorder_en,
    output logic [REG_ID_W-1:0] reorder_reg,
    output logic [ROB_ID_W-1:0] reorder_id,
    output logic                d_to_rob,
    output logic                d_to_rs,
    output logic                d_to_lsb,
    output logic [5:0]          d_op_type,
    output logic [31:0]         d_imm,
    output logic [31:0]         d_pc,
    output logic                d_predict,
    output logic [REG_ID_W-1:0] d_dest,
    output logic [ROB_ID_W-1:0] d_rob_id,
    output logic                d_j,
    output logic                d_k,
    output logic [31:0]         d_vj,
    output logic [31:0]         d_vk,
    output logic [ROB_ID_W-1:0] d_qj,
    output logic [ROB_ID_W-1:0] d_qk
);
    localparam int               PTR_W     = $clog2(IQ_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(IQ_DEPTH);

    typedef struct packed {
        logic                rdy;
        logic [31:0]         val;
        logic [ROB_ID_W-1:0] tag;
    } opnd_t;

    iq_entry_t          mem [IQ_DEPTH];
    logic [PTR_W-1:0]   head, tail;
    logic [PTR_W:0]     count;
    iq_entry_t          head_e;
    dec_t               dec;
    logic               push, pop, unit_full;
    opnd_t              op1, op2;

    // x0 and unused sources resolve to ready zero regardless of regfile state
    function automatic opnd_t resolve(
        input logic [4:0]          rs,
        input logic                busy,
        input logic [31:0]         rf_val,
        input logic [ROB_ID_W-1:0] re,
        input logic                rob_rdy,
        input logic [31:0]         rob_val,
        input logic                cv,
        input logic [ROB_ID_W-1:0] cid,
        input logic [31:0]         cval
    );
        opnd_t o;
        o = '{rdy: 1'b1, val: 32'd0, tag: '0};
        if (rs != 5'd0) begin
            if (!busy)                  o.val = rf_val;
            else if (rob_rdy)           o.val = rob_val;
            else if (cv && cid == re)   o.val = cval;
            else begin
                o.rdy = 1'b0;
                o.tag = re;
            end
        end
        return o;
    endfunction

    assign head_e = mem[head];

    decode_queue_inst_decode u_dec (
        .inst (head_e.inst),
        .pc   (head_e.pc),
        .dec  (dec)
    );

    assign if_ready  = (count < DEPTH_CNT);
    assign unit_full = dec.to_lsb ? lsb_full : rs_full;
    assign push      = rdy_in && !flush_in && if_valid && if_ready;
    assign pop       = rdy_in && !flush_in && (count != '0) && !rob_full && !unit_full;

    assign rs1_id      = REG_ID_W'(dec.rs1);
    assign rs2_id      = REG_ID_W'(dec.rs2);
    assign reorder_en  = pop && (dec.rd != 5'd0);
    assign reorder_reg = REG_ID_W'(dec.rd);
    assign reorder_id  = rob_free_id;

    assign op1 = resolve(dec.rs1, rs1_busy, rs1_value, rs1_re, rob_rs1_ready, rob_rs1_value,
                         cdb_valid, cdb_rob_id, cdb_value);
    assign op2 = resolve(dec.rs2, rs2_busy, rs2_value, rs2_re, rob_rs2_ready, rob_rs2_value,
                         cdb_valid, cdb_rob_id, cdb_value);

    always_ff @(posedge clk_in) begin
        if (push) mem[tail] <= '{pc: if_pc, inst: if_inst, predict: if_predict};
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + 1'b1;
                if (pop)  head <= head + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            d_to_rob  <= 1'b0;
            d_to_rs   <= 1'b0;
            d_to_lsb  <= 1'b0;
            d_op_type <= '0;
            d_imm     <= '0;
            d_pc      <= '0;
            d_predict <= 1'b0;
            d_dest    <= '0;
            d_rob_id  <= '0;
            d_j       <= 1'b0;
            d_k       <= 1'b0;
            d_vj      <= '0;
            d_vk      <= '0;
            d_qj      <= '0;
            d_qk      <= '0;
        end else begin
            d_to_rob <= pop;
            d_to_rs  <= pop && !dec.to_lsb;
            d_to_lsb <= pop && dec.to_lsb;
            if (pop) begin
                d_op_type <= dec.op;
                d_imm     <= dec.imm;
                d_pc      <= head_e.pc;
                d_predict <= head_e.predict;
                d_dest    <= REG_ID_W'(dec.rd);
                d_rob_id  <= rob_free_id;
                d_j       <= op1.rdy;
                d_k       <= op2.rdy;
                d_vj      <= op1.val;
                d_vk      <= op2.val;
                d_qj      <= op1.tag;
                d_qk      <= op2.tag;
            end
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: expected packets queued at push, compared on each dispatch strobe.
module tb_decode_queue;

    logic        clk = 1'b0;
    logic        rst_n, rdy_in, flush_in, if_valid, if_predict, if_ready;
    logic [31:0] if_pc, if_inst;
    logic        rs1_busy, rs2_busy, rob_rs1_ready, rob_rs2_ready;
    logic [31:0] rs1_value, rs2_value, rob_rs1_value, rob_rs2_value, cdb_value;
    logic [3:0]  rs1_re, rs2_re, rob_free_id, cdb_rob_id;
    logic        rob_full, rs_full, lsb_full, cdb_valid;
    logic [4:0]  rs1_id, rs2_id, reorder_reg, d_dest;
    logic        reorder_en, d_to_rob, d_to_rs, d_to_lsb, d_predict, d_j, d_k;
    logic [3:0]  reorder_id, d_rob_id, d_qj, d_qk;
    logic [5:0]  d_op_type;
    logic [31:0] d_imm, d_pc, d_vj, d_vk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        pred;
        logic [4:0]  dest;
        logic [3:0]  rob;
        logic        lsb;
        logic        j;
        logic [31:0] vj;
        logic [3:0]  qj;
        logic        k;
        logic [31:0] vk;
        logic [3:0]  qk;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    decode_queue dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy_in), .flush_in(flush_in),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_predict(if_predict),
        .if_ready(if_ready),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rs1_value(rs1_value), .rs2_value(rs2_value),
        .rs1_re(rs1_re), .rs2_re(rs2_re),
        .rob_rs1_ready(rob_rs1_ready), .rob_rs2_ready(rob_rs2_ready),
        .rob_rs1_value(rob_rs1_value), .rob_rs2_value(rob_rs2_value),
        .rob_full(rob_full), .rob_free_id(rob_free_id), .rs_full(rs_full), .lsb_full(lsb_full),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .reorder_en(reorder_en), .reorder_reg(reorder_reg), .reorder_id(reorder_id),
        .d_to_rob(d_to_rob), .d_to_rs(d_to_rs), .d_to_lsb(d_to_lsb),
        .d_op_type(d_op_type), .d_imm(d_imm), .d_pc(d_pc), .d_predict(d_predict),
        .d_dest(d_dest), .d_rob_id(d_rob_id),
        .d_j(d_j), .d_k(d_k), .d_vj(d_vj), .d_vk(d_vk), .d_qj(d_qj), .d_qk(d_qk)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [5:0] op, input logic [31:0] imm, input logic [31:0] pc,
                                input logic pred, input logic [4:0] dest, input logic [3:0] rob,
                                input logic lsb, input logic j, input logic [31:0] vj,
                                input logic [3:0] qj, input logic k, input logic [31:0] vk,
                                input logic [3:0] qk);
        exp_t e;
        e.op = op; e.imm = imm; e.pc = pc; e.pred = pred; e.dest = dest; e.rob = rob;
        e.lsb = lsb; e.j = j; e.vj = vj; e.qj = qj; e.k = k; e.vk = vk; e.qk = qk;
        return e;
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'h13};
    endfunction

    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'h03};
    endfunction

    function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    always @(negedge clk) begin
        if (rst_n && d_to_rob) begin
            if (sb.size() == 0) begin
                chk("extra_dispatch_pc", d_pc, 32'hDEAD_DEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("d_pc", d_pc, e.pc);
                chk("d_op_type", d_op_type, e.op);
                chk("d_imm", d_imm, e.imm);
                chk("d_predict", d_predict, e.pred);
                chk("d_dest", d_dest, e.dest);
                chk("d_rob_id", d_rob_id, e.rob);
                chk("d_to_lsb", d_to_lsb, e.lsb);
                chk("d_to_rs", d_to_rs, !e.lsb);
                chk("d_j", d_j, e.j);
                chk("d_vj", d_vj, e.vj);
                chk("d_qj", d_qj, e.qj);
                chk("d_k", d_k, e.k);
                chk("d_vk", d_vk, e.vk);
                chk("d_qk", d_qk, e.qk);
            end
        end
    end

    task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic pred);
        if_valid = 1'b1; if_pc = pc; if_inst = inst; if_predict = pred;
        @(posedge clk); #1;
        if_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 64 && sb.size() != 0; n++) @(posedge clk);
        chk("drain_left", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic defaults();
        rdy_in = 1'b1; flush_in = 1'b0; if_valid = 1'b0; if_predict = 1'b0;
        rs1_busy = 1'b0; rs2_busy = 1'b0; rs1_re = 4'd0; rs2_re = 4'd0;
        rs1_value = 32'hAAAA_0001; rs2_value = 32'hBBBB_0002;
        rob_rs1_ready = 1'b0; rob_rs2_ready = 1'b0; rob_rs1_value = 32'h0; rob_rs2_value = 32'h0;
        rob_full = 1'b0; rob_free_id = 4'd2; rs_full = 1'b0; lsb_full = 1'b0;
        cdb_valid = 1'b0; cdb_rob_id = 4'd0; cdb_value = 32'h0;
    endtask

    initial begin
        defaults();
        if_pc = '0; if_inst = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_if_ready", if_ready, 1);
        chk("rst_to_rob", d_to_rob, 0);
        chk("rst_to_rs", d_to_rs, 0);
        chk("rst_to_lsb", d_to_lsb, 0);
        chk("rst_op_type", d_op_type, 0);
        chk("rst_pc", d_pc, 0);
        chk("rst_reorder_en", reorder_en, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // addi x1,x0,5 at pc 0
        sb.push_back(mk(6'd18, 32'd5, 32'h0, 1'b0, 5'd1, 4'd2, 1'b0, 1'b1, 32'h0, 4'd0, 1'b1, 32'h0, 4'd0));
        push(32'h0, addi(5'd1, 5'd0, 12'd5), 1'b0);
        @(negedge clk);
        chk("t1_latency", d_to_rob, 0);
        chk("t1_reorder_en", reorder_en, 1);
        chk("t1_reorder_reg", reorder_reg, 1);
        chk("t1_reorder_id", reorder_id, 2);
        @(negedge clk);
        chk("t1_to_rs", d_to_rs, 1);
        wait_drain();

        // fill to capacity while the ROB is full
        rob_full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if_valid = 1'b1; if_pc = 32'(4 * i); if_inst = addi(5'd1, 5'd0, 12'(i)); if_predict = 1'b0;
            @(negedge clk);
            chk("t2_if_ready", if_ready, i < 8);
            if (i < 8)
                sb.push_back(mk(6'd18, 32'(i), 32'(4 * i), 1'b0, 5'd1, 4'd2, 1'b0,
                                1'b1, 32'h0, 4'd0, 1'b1, 32'h0, 4'd0));
            @(posedge clk); #1;
        end
        if_pc = 32'h999; if_inst = addi(5'd1, 5'd0, 12'd9);
        rob_full = 1'b0;
        @(negedge clk);
        chk("t2_no_pushthrough", if_ready, 0);
        @(posedge clk); #1;
        if_valid = 1'b0;
        wait_drain();

        // load with renamed source woken by the CDB, LSB stalled first
        rs1_busy = 1'b1; rs1_re = 4'd3; rob_rs1_ready = 1'b0;
        cdb_valid = 1'b1; cdb_rob_id = 4'd3; cdb_value = 32'h100;
        lsb_full = 1'b1; rs_full = 1'b1;
        sb.push_back(mk(6'd12, 32'd4, 32'h200, 1'b0, 5'd2, 4'd2, 1'b1, 1'b1, 32'h100, 4'd0, 1'b1, 32'h0, 4'd0));
        push(32'h200, lw(5'd2, 5'd1, 12'd4), 1'b0);
        @(negedge clk);
        chk("t3_rs1_id", rs1_id, 1);
        chk("t3_no_rename_stalled", reorder_en, 0);
        repeat (3) begin
            @(negedge clk);
            chk("t3_lsb_stall", d_to_rob, 0);
        end
        @(posedge clk); #1;
        lsb_full = 1'b0;
        wait_drain();
        defaults();

        // add x3,x3,x4: rs1 pending tag 7 (CDB on another tag), rs2 from ROB bypass
        rob_free_id = 4'd5;
        rs1_busy = 1'b1; rs1_re = 4'd7;
        rs2_busy = 1'b1; rs2_re = 4'd9; rob_rs2_ready = 1'b1; rob_rs2_value = 32'hC0DE_0000;
        cdb_valid = 1'b1; cdb_rob_id = 4'd6; cdb_value = 32'h55;
        sb.push_back(mk(6'd27, 32'h0, 32'h300, 1'b0, 5'd3, 4'd5, 1'b0,
                        1'b0, 32'h0, 4'd7, 1'b1, 32'hC0DE_0000, 4'd0));
        push(32'h300, add(5'd3, 5'd3, 5'd4), 1'b0);
        @(negedge clk);
        chk("t4_reorder_en", reorder_en, 1);
        chk("t4_reorder_reg", reorder_reg, 3);
        chk("t4_reorder_id", reorder_id, 5);
        chk("t4_rs1_id", rs1_id, 3);
        chk("t4_rs2_id", rs2_id, 4);
        wait_drain();
        defaults();

        // assorted formats back to back
        sb.push_back(mk(6'd17, 32'd8, 32'h400, 1'b0, 5'd0, 4'd2, 1'b1,
                        1'b1, 32'hAAAA_0001, 4'd0, 1'b1, 32'hBBBB_0002, 4'd0));
        push(32'h400, {7'h00, 5'd5, 5'd2, 3'b010, 5'd8, 7'h23}, 1'b0);
        sb.push_back(mk(6'd4, 32'hFFFF_FFF8, 32'h404, 1'b1, 5'd0, 4'd2, 1'b0,
                        1'b1, 32'hAAAA_0001, 4'd0, 1'b1, 32'hBBBB_0002, 4'd0));
        push(32'h404, {1'b1, 6'b111111, 5'd2, 5'd1, 3'b000, 4'b1100, 1'b1, 7'h63}, 1'b1);
        sb.push_back(mk(6'd1, 32'h1234_5408, 32'h408, 1'b0, 5'd7, 4'd2, 1'b0,
                        1'b1, 32'h0, 4'd0, 1'b1, 32'h0, 4'd0));
        push(32'h408, {20'h12345, 5'd7, 7'h17}, 1'b0);
        sb.push_back(mk(6'd26, 32'd3, 32'h40C, 1'b0, 5'd6, 4'd2, 1'b0,
                        1'b1, 32'hAAAA_0001, 4'd0, 1'b1, 32'h0, 4'd0));
        push(32'h40C, {7'h20, 5'd3, 5'd6, 3'b101, 5'd6, 7'h13}, 1'b0);
        sb.push_back(mk(6'd39, 32'h0, 32'h410, 1'b0, 5'd0, 4'd2, 1'b0,
                        1'b1, 32'h0, 4'd0, 1'b1, 32'h0, 4'd0));
        push(32'h410, 32'h0000_0000, 1'b0);
        wait_drain();

        // flush with 4 queued, fetch offering, and a pop that would otherwise fire
        rob_full = 1'b1;
        for (int i = 0; i < 4; i++) push(32'h500 + 32'(4 * i), addi(5'd8, 5'd0, 12'(i)), 1'b0);
        if_valid = 1'b1; if_pc = 32'h600; if_inst = addi(5'd9, 5'd0, 12'd1);
        flush_in = 1'b1; rob_full = 1'b0;
        @(negedge clk);
        chk("t5_flush_no_rename", reorder_en, 0);
        @(posedge clk); #1;
        flush_in = 1'b0; if_valid = 1'b0;
        @(negedge clk);
        chk("t5_no_strobe", d_to_rob, 0);
        chk("t5_if_ready", if_ready, 1);
        repeat (3) begin
            @(negedge clk);
            chk("t5_empty", d_to_rob, 0);
        end
        @(posedge clk); #1;
        sb.push_back(mk(6'd18, 32'd7, 32'h700, 1'b0, 5'd4, 4'd2, 1'b0,
                        1'b1, 32'h0, 4'd0, 1'b1, 32'h0, 4'd0));
        push(32'h700, addi(5'd4, 5'd0, 12'd7), 1'b0);
        wait_drain();

        // pause for three edges right after the first dispatch
        rob_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(mk(6'd18, 32'(i + 1), 32'h800 + 32'(4 * i), 1'b0, 5'd5, 4'd2, 1'b0,
                            1'b1, 32'h0, 4'd0, 1'b1, 32'h0, 4'd0));
            push(32'h800 + 32'(4 * i), addi(5'd5, 5'd0, 12'(i + 1)), 1'b0);
        end
        rob_full = 1'b0;
        @(posedge clk); #1;
        rdy_in = 1'b0;
        if_valid = 1'b1; if_pc = 32'h900; if_inst = addi(5'd10, 5'd0, 12'd10);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("t6_pause_strobe", d_to_rob, 0);
            chk("t6_pause_pc", d_pc, 32'h800);
            chk("t6_pause_rename", reorder_en, 0);
        end
        rdy_in = 1'b1; if_valid = 1'b0;
        wait_drain();

        // asynchronous reset with entries pending
        rob_full = 1'b1;
        push(32'hA00, addi(5'd1, 5'd0, 12'd1), 1'b0);
        push(32'hA04, addi(5'd1, 5'd0, 12'd2), 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("t7_arst_if_ready", if_ready, 1);
        chk("t7_arst_rename", reorder_en, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; rob_full = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t7_arst_empty", d_to_rob, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
